// File: rtl/spi_master.sv
// SPI master that serialises {write flag, read flag, address, data} packets MSB-first,
// with programmable SCLK half-period and chip-select setup, hold and inter-packet gap.
module spi_master #(
    parameter int HEADER   = 2,
    parameter int ADDRSZ   = 7,
    parameter int PAYLOAD  = 8,
    parameter int PKTSZ    = HEADER + ADDRSZ + PAYLOAD,
    parameter int HALF     = 8,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int GAP      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_rw,
    input  logic [ADDRSZ-1:0]  cmd_addr,
    input  logic [PAYLOAD-1:0] cmd_wdata,
    output logic               rsp_valid,
    output logic [PAYLOAD-1:0] rsp_rdata,
    output logic               busy,
    output logic               SCLK,
    output logic               SSB,
    output logic               MOSI,
    input  logic               MISO
);

    localparam int MAX_A = (HALF > CS_SETUP) ? HALF : CS_SETUP;
    localparam int MAX_B = (CS_HOLD > GAP) ? CS_HOLD : GAP;
    localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_T + 1);

    localparam logic [CW-1:0] HALF_LD  = CW'(HALF - 1);
    localparam logic [CW-1:0] SETUP_LD = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    localparam logic [4:0] LAST_BIT   = 5'(PKTSZ - 1);
    localparam logic [4:0] FIRST_DATA = 5'(HEADER + ADDRSZ);
    localparam logic [4:0] BIT_ONE    = 5'd1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // Read packets carry zeros in the payload slot so MOSI stays low while the slave answers.
    function automatic logic [PKTSZ-1:0] build_packet(
        input logic               rw,
        input logic [ADDRSZ-1:0]  addr,
        input logic [PAYLOAD-1:0] wdata
    );
        logic [PAYLOAD-1:0] data_s;
        data_s = rw ? {PAYLOAD{1'b0}} : wdata;
        return {~rw, rw, addr, data_s};
    endfunction

    state_t             state_r, state_s;
    logic [CW-1:0]      cnt_r, cnt_s;
    logic [4:0]         bit_r, bit_s;
    logic               high_r, high_s;
    logic [PKTSZ-1:0]   pkt_r, pkt_s;
    logic [PKTSZ-1:0]   packet_s;
    logic [PAYLOAD-1:0] rx_r, rx_s;
    logic               rw_r, rw_s;
    logic               sclk_r, sclk_s;
    logic               ssb_r, ssb_s;
    logic               mosi_r, mosi_s;
    logic               ready_r, ready_s;
    logic               busy_r, busy_s;
    logic               rsp_valid_r, rsp_valid_s;
    logic [PAYLOAD-1:0] rdata_r, rdata_s;
    logic               miso_meta_r, miso_sync_r;

    // Two-flop synchroniser for the asynchronous MISO line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            miso_meta_r <= 1'b0;
            miso_sync_r <= 1'b0;
        end else begin
            miso_meta_r <= MISO;
            miso_sync_r <= miso_meta_r;
        end
    end

    // Next-state and next-output logic for the packet sequencer.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        bit_s       = bit_r;
        high_s      = high_r;
        pkt_s       = pkt_r;
        rx_s        = rx_r;
        rw_s        = rw_r;
        sclk_s      = sclk_r;
        ssb_s       = ssb_r;
        mosi_s      = mosi_r;
        rsp_valid_s = 1'b0;
        rdata_s     = rdata_r;
        packet_s    = build_packet(cmd_rw, cmd_addr, cmd_wdata);
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid && ready_r) begin
                    state_s = ST_SETUP;
                    cnt_s   = SETUP_LD;
                    bit_s   = 5'd0;
                    high_s  = 1'b0;
                    pkt_s   = {packet_s[PKTSZ-2:0], 1'b0};
                    rx_s    = {PAYLOAD{1'b0}};
                    rw_s    = cmd_rw;
                    ssb_s   = 1'b0;
                    mosi_s  = packet_s[PKTSZ-1];
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_SHIFT;
                    cnt_s   = HALF_LD;
                    high_s  = 1'b1;
                    sclk_s  = 1'b1;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_s = cnt_r - CNT_ONE;
                end else if (high_r) begin
                    // End of the high phase: sample the slave before SCLK falls.
                    high_s = 1'b0;
                    sclk_s = 1'b0;
                    cnt_s  = HALF_LD;
                    if (bit_r >= FIRST_DATA) begin
                        rx_s = {rx_r[PAYLOAD-2:0], miso_sync_r};
                    end else begin
                        rx_s = rx_r;
                    end
                end else if (bit_r == LAST_BIT) begin
                    state_s = ST_HOLD;
                    cnt_s   = HOLD_LD;
                end else begin
                    bit_s  = bit_r + BIT_ONE;
                    high_s = 1'b1;
                    sclk_s = 1'b1;
                    cnt_s  = HALF_LD;
                    mosi_s = pkt_r[PKTSZ-1];
                    pkt_s  = {pkt_r[PKTSZ-2:0], 1'b0};
                end
            end
            ST_HOLD: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_GAP;
                    cnt_s   = GAP_LD;
                    ssb_s   = 1'b1;
                    mosi_s  = 1'b0;
                    if (rw_r) begin
                        rsp_valid_s = 1'b1;
                        rdata_s     = rx_r;
                    end else begin
                        rsp_valid_s = 1'b0;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
                sclk_s  = 1'b0;
                ssb_s   = 1'b1;
                mosi_s  = 1'b0;
            end
        endcase
        ready_s = (state_s == ST_IDLE);
        busy_s  = (state_s != ST_IDLE);
    end

    // Sequencer state and registered SPI/handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            bit_r       <= 5'd0;
            high_r      <= 1'b0;
            pkt_r       <= {PKTSZ{1'b0}};
            rx_r        <= {PAYLOAD{1'b0}};
            rw_r        <= 1'b0;
            sclk_r      <= 1'b0;
            ssb_r       <= 1'b1;
            mosi_r      <= 1'b0;
            ready_r     <= 1'b0;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            rdata_r     <= {PAYLOAD{1'b0}};
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            bit_r       <= bit_s;
            high_r      <= high_s;
            pkt_r       <= pkt_s;
            rx_r        <= rx_s;
            rw_r        <= rw_s;
            sclk_r      <= sclk_s;
            ssb_r       <= ssb_s;
            mosi_r      <= mosi_s;
            ready_r     <= ready_s;
            busy_r      <= busy_s;
            rsp_valid_r <= rsp_valid_s;
            rdata_r     <= rdata_s;
        end
    end

    assign cmd_ready = ready_r;
    assign busy      = busy_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rdata_r;
    assign SCLK      = sclk_r;
    assign SSB       = ssb_r;
    assign MOSI      = mosi_r;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: instance 0 uses HALF=8, instance 1 uses HALF=2; a monitor with
// a slave model observes both buses and each transaction is checked against a packet model.
module tb_spi_master;

    localparam int NI       = 2;
    localparam int CS_SETUP = 4;
    localparam int CS_HOLD  = 4;
    localparam int GAP      = 4;
    localparam int PKTSZ    = 17;
    localparam int BOUND    = 2000;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid [NI];
    logic       cmd_rw    [NI];
    logic [6:0] cmd_addr  [NI];
    logic [7:0] cmd_wdata [NI];
    logic       cmd_ready [NI];
    logic       rsp_valid [NI];
    logic [7:0] rsp_rdata [NI];
    logic       busy      [NI];
    logic       sclk      [NI];
    logic       ssb       [NI];
    logic       mosi      [NI];
    logic       miso      [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        spi_master #(.HALF(g == 0 ? 8 : 2)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .cmd_valid (cmd_valid[g]),
            .cmd_ready (cmd_ready[g]),
            .cmd_rw    (cmd_rw[g]),
            .cmd_addr  (cmd_addr[g]),
            .cmd_wdata (cmd_wdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_rdata (rsp_rdata[g]),
            .busy      (busy[g]),
            .SCLK      (sclk[g]),
            .SSB       (ssb[g]),
            .MOSI      (mosi[g]),
            .MISO      (miso[g])
        );
    end

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor state, written only by the monitor process.
    int          rises [NI]         = '{default: 0};
    int          falls [NI]         = '{default: 0};
    int          pkt_falls [NI]     = '{default: 0};
    int          ssb_low [NI]       = '{default: 0};
    int          ssb_rise_cyc [NI]  = '{default: 0};
    int          high_run [NI]      = '{default: 0};
    int          last_high_run [NI] = '{default: 0};
    int          rsp_cnt [NI]       = '{default: 0};
    int          rsp_cyc [NI]       = '{default: 0};
    int          busy_fall_cyc [NI] = '{default: 0};
    int          bad_ready [NI]     = '{default: 0};
    int          last_rise [NI]     = '{default: 0};
    int          rise_period [NI]   = '{default: 0};
    logic [31:0] cap [NI]           = '{default: 32'd0};
    logic        sclk_q [NI]        = '{default: 1'b0};
    logic        ssb_q [NI]         = '{default: 1'b1};
    logic        busy_q [NI]        = '{default: 1'b0};

    // Stimulus-side state.
    logic [7:0] slave_data [NI];
    logic [7:0] model_rdata [NI];
    int snap_r, snap_f, snap_rsp, snap_low;
    int errors = 0;
    int checks = 0;

    function automatic int half_of(input int i);
        return (i == 0) ? 8 : 2;
    endfunction

    function automatic int lat_of(input int i);
        return 1 + CS_SETUP + PKTSZ * 2 * half_of(i) + CS_HOLD;
    endfunction

    // Expected 17-bit packet: write flag, read flag, address, data (zero on reads).
    function automatic logic [16:0] exp_pkt(input bit rw, input logic [6:0] a, input logic [7:0] wd);
        int v;
        v = (rw ? 0 : 1) * 65536 + (rw ? 1 : 0) * 32768 + int'(a) * 256 + (rw ? 0 : int'(wd));
        return 17'(v);
    endfunction

    // Slave answer bit for packet bit index nb (payload occupies bits 9..16, MSB first).
    function automatic logic slave_bit(input int i, input int nb);
        logic [7:0] d;
        d = slave_data[i];
        if (nb >= 9 && nb <= 16) return d[16-nb];
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            sclk_q[i] <= sclk[i];
            ssb_q[i]  <= ssb[i];
            busy_q[i] <= busy[i];
            if (sclk[i] && !sclk_q[i]) begin
                rises[i]       <= rises[i] + 1;
                rise_period[i] <= cyc - last_rise[i];
                last_rise[i]   <= cyc;
            end
            if (!sclk[i] && sclk_q[i]) begin
                falls[i]     <= falls[i] + 1;
                cap[i]       <= {cap[i][30:0], mosi[i]};
                pkt_falls[i] <= pkt_falls[i] + 1;
                miso[i]      <= slave_bit(i, pkt_falls[i] + 1);
            end else if (!reset) begin
                miso[i] <= 1'b0;
            end
            if (!ssb[i] && ssb_q[i]) begin
                pkt_falls[i]     <= 0;
                last_high_run[i] <= high_run[i];
            end
            if (ssb[i] && !ssb_q[i]) ssb_rise_cyc[i] <= cyc;
            if (ssb[i]) high_run[i] <= high_run[i] + 1;
            else begin
                high_run[i] <= 0;
                ssb_low[i]  <= ssb_low[i] + 1;
            end
            if (rsp_valid[i]) begin
                rsp_cnt[i] <= rsp_cnt[i] + 1;
                rsp_cyc[i] <= cyc;
            end
            if (!busy[i] && busy_q[i]) busy_fall_cyc[i] <= cyc;
            if (cmd_ready[i] && !ssb[i]) bad_ready[i] <= bad_ready[i] + 1;
        end
    end

    task automatic check(input string tag, input int i, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d]: observed=%0h expected=%0h", tag, i, obs, exp);
        end
    endtask

    task automatic snap(input int i);
        snap_r   = rises[i];
        snap_f   = falls[i];
        snap_rsp = rsp_cnt[i];
        snap_low = ssb_low[i];
    endtask

    task automatic drive(input int i, input bit rw, input logic [6:0] a, input logic [7:0] wd);
        cmd_valid[i] = 1'b1;
        cmd_rw[i]    = rw;
        cmd_addr[i]  = a;
        cmd_wdata[i] = wd;
    endtask

    // Called at a negedge with cmd_valid high; returns at the negedge after acceptance.
    task automatic wait_accept(input int i, output int acc);
        bit ok;
        ok  = 1'b0;
        acc = 0;
        for (int k = 0; k < BOUND; k++) begin
            if (cmd_ready[i]) begin
                acc = cyc;
                ok  = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("accept_timeout", i, 64'(ok), 64'd1);
        @(negedge clk);
    endtask

    task automatic wait_idle(input int i, input bit toggle);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < BOUND; k++) begin
            if (!busy[i]) begin
                ok = 1'b1;
                break;
            end
            if (toggle) begin
                cmd_addr[i]  = ~cmd_addr[i];
                cmd_wdata[i] = 8'($urandom);
                cmd_rw[i]    = ~cmd_rw[i];
            end
            @(negedge clk);
        end
        check("idle_timeout", i, 64'(ok), 64'd1);
        #1;
    endtask

    task automatic check_txn(input int i, input bit rw, input logic [6:0] a, input logic [7:0] wd,
                             input logic [7:0] sd, input int acc);
        int lat;
        lat = lat_of(i);
        check("packet_bits", i, 64'(cap[i][16:0]), 64'(exp_pkt(rw, a, wd)));
        check("sclk_rises", i, 64'(rises[i] - snap_r), 64'(PKTSZ));
        check("sclk_falls", i, 64'(falls[i] - snap_f), 64'(PKTSZ));
        check("accept_to_ssb_rise", i, 64'(ssb_rise_cyc[i] - acc), 64'(lat));
        check("ssb_low_cycles", i, 64'(ssb_low[i] - snap_low), 64'(lat - 1));
        check("busy_after_ssb_rise", i, 64'(busy_fall_cyc[i] - ssb_rise_cyc[i]), 64'(GAP));
        check("bit_period", i, 64'(rise_period[i]), 64'(2 * half_of(i)));
        check("rsp_pulses", i, 64'(rsp_cnt[i] - snap_rsp), rw ? 64'd1 : 64'd0);
        if (rw) begin
            model_rdata[i] = sd;
            check("rsp_cycle", i, 64'(rsp_cyc[i]), 64'(ssb_rise_cyc[i]));
        end
        check("rsp_rdata", i, 64'(rsp_rdata[i]), 64'(model_rdata[i]));
    endtask

    task automatic run_txn(input int i, input bit rw, input logic [6:0] a, input logic [7:0] wd,
                           input logic [7:0] sd, input bit toggle);
        int acc;
        snap(i);
        slave_data[i] = sd;
        @(negedge clk);
        drive(i, rw, a, wd);
        wait_accept(i, acc);
        cmd_valid[i] = 1'b0;
        wait_idle(i, toggle);
        check_txn(i, rw, a, wd, sd, acc);
    endtask

    initial begin
        int         acc1, acc2, br;
        bit         ok;
        bit         rw;
        logic [6:0] a;
        logic [7:0] wd, sd;

        for (int i = 0; i < NI; i++) begin
            cmd_valid[i]   = 1'b0;
            cmd_rw[i]      = 1'b0;
            cmd_addr[i]    = 7'd0;
            cmd_wdata[i]   = 8'd0;
            slave_data[i]  = 8'd0;
            model_rdata[i] = 8'd0;
        end

        // Reset values, then cmd_ready on the first clock after release.
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++)
            check("reset_outputs", i,
                  64'({sclk[i], ssb[i], mosi[i], cmd_ready[i], busy[i], rsp_valid[i], rsp_rdata[i]}),
                  64'({6'b010000, 8'h00}));
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) check("ready_after_reset", i, 64'(cmd_ready[i]), 64'd1);

        // Directed write and read, then the same write on the HALF=2 instance.
        run_txn(0, 1'b0, 7'h15, 8'hA5, 8'h00, 1'b0);
        run_txn(0, 1'b1, 7'h7F, 8'h00, 8'h3C, 1'b0);
        run_txn(1, 1'b0, 7'h15, 8'hA5, 8'h00, 1'b0);
        run_txn(1, 1'b1, 7'h00, 8'hFF, 8'hC3, 1'b0);

        // Randomized packets on both instances.
        for (int n = 0; n < 6; n++) begin
            rw = 1'($urandom_range(0, 1));
            a  = 7'($urandom);
            wd = 8'($urandom);
            sd = 8'($urandom);
            run_txn(n % 2, rw, a, wd, sd, 1'b0);
        end

        // Back-to-back with cmd_valid held: second command waits out the gap.
        snap(0);
        br = bad_ready[0];
        @(negedge clk);
        drive(0, 1'b0, 7'h2A, 8'h3C);
        wait_accept(0, acc1);
        slave_data[0] = 8'h96;
        drive(0, 1'b1, 7'h55, 8'hFF);
        wait_accept(0, acc2);
        cmd_valid[0] = 1'b0;
        wait_idle(0, 1'b0);
        check("b2b_accept_spacing", 0, 64'(acc2 - acc1), 64'(lat_of(0) + GAP));
        check("b2b_ssb_high_min", 0, 64'(last_high_run[0] >= GAP), 64'd1);
        check("b2b_ready_in_packet", 0, 64'(bad_ready[0] - br), 64'd0);
        check("b2b_rises", 0, 64'(rises[0] - snap_r), 64'(2 * PKTSZ));
        check("b2b_packet2", 0, 64'(cap[0][16:0]), 64'(exp_pkt(1'b1, 7'h55, 8'hFF)));
        check("b2b_rsp_pulses", 0, 64'(rsp_cnt[0] - snap_rsp), 64'd1);
        model_rdata[0] = 8'h96;
        check("b2b_rdata", 0, 64'(rsp_rdata[0]), 64'(model_rdata[0]));

        // Command inputs toggled every cycle after acceptance.
        run_txn(0, 1'b0, 7'h4B, 8'h96, 8'h00, 1'b1);
        run_txn(1, 1'b1, 7'h2D, 8'hFF, 8'hB7, 1'b1);

        // Reset during bit 9 of a read: immediate idle bus, no response, no resume.
        snap(0);
        slave_data[0] = 8'h5A;
        @(negedge clk);
        drive(0, 1'b1, 7'h19, 8'h00);
        wait_accept(0, acc1);
        cmd_valid[0] = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < BOUND; k++) begin
            @(negedge clk);
            #1;
            if (rises[0] - snap_r >= 10) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_reach_bit9", 0, 64'(ok), 64'd1);
        #2;
        check("sclk_high_in_bit9", 0, 64'(sclk[0]), 64'd1);
        reset = 1'b0;
        #1;
        check("abort_ssb", 0, 64'(ssb[0]), 64'd1);
        check("abort_sclk", 0, 64'(sclk[0]), 64'd0);
        repeat (3) @(negedge clk);
        check("abort_idle_outputs", 0, 64'({busy[0], cmd_ready[0], rsp_valid[0], mosi[0]}), 64'd0);
        reset = 1'b1;
        model_rdata[0] = 8'h00;
        model_rdata[1] = 8'h00;
        repeat (20) @(negedge clk);
        #1;
        check("abort_no_rsp", 0, 64'(rsp_cnt[0] - snap_rsp), 64'd0);
        check("abort_not_resumed", 0, 64'(ssb[0]), 64'd1);
        run_txn(0, 1'b0, 7'h33, 8'hC6, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
